// File: rtl/edge_arb_pkg.sv
// ---------------------------------------------------------------------------
// edge_arb_pkg
//
// Shared types for the edge-event arbiter slice.
//   edge_mode_t : per-channel detection mode (off / rise / fall / both)
//   arb_state_t : arbiter FSM states (IDLE / PRESENT)
//   modeAllows  : decides whether an edge of a given polarity is enabled
//                 under a given mode
// ---------------------------------------------------------------------------
package edge_arb_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_RISE = 2'd1,
        MODE_FALL = 2'd2,
        MODE_BOTH = 2'd3
    } edge_mode_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } arb_state_t;

    // True when an edge whose new level is 'rising' (1 = rising, 0 = falling)
    // is allowed to raise a pending event under 'mode'.
    function automatic logic modeAllows(input edge_mode_t mode, input logic rising);
        logic allowed;
        case (mode)
            MODE_RISE: allowed = rising;
            MODE_FALL: allowed = ~rising;
            MODE_BOTH: allowed = 1'b1;
            default:   allowed = 1'b0;
        endcase
        return allowed;
    endfunction

endpackage

// File: rtl/edge_arb_chan.sv
// ---------------------------------------------------------------------------
// edge_arb_chan
//
// One input channel of the edge-event arbiter: remembers the previous level,
// gates detected edges by the channel mode, and latches a pending event with
// its polarity until the arbiter clears it.
//
// Optional feature macro: EDGE_ARB_OVERRUN_EN adds the sticky overrun flag.
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-high reset
//   in_i    in   level input, already synchronous to clk
//   mode_i  in   2-bit detection mode (edge_mode_t encoding)
//   clr_i   in   arbiter accepted this channel's event this cycle
//   pend_o  out  an event is pending on this channel
//   pol_o   out  polarity of the pending event (1 = rising)
//   ovr_o   out  sticky overrun flag (only with EDGE_ARB_OVERRUN_EN)
// ---------------------------------------------------------------------------
module edge_arb_chan
    import edge_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_i,
    input  logic [1:0] mode_i,
    input  logic       clr_i,
    output logic       pend_o,
    output logic       pol_o
`ifdef EDGE_ARB_OVERRUN_EN
    ,
    output logic       ovr_o
`endif
);

    logic prevLevel_q;
    logic pend_q;
    logic pend_d;
    logic pol_q;
    logic pol_d;
    logic edgeEnabled;

    // An edge is any difference between the current level and last cycle's
    // level; prevLevel_q tracks the input regardless of mode, so turning a
    // mode on never manufactures a stale edge.
    assign edgeEnabled = (in_i != prevLevel_q) && modeAllows(edge_mode_t'(mode_i), in_i);

    // Pending-event next state. A new edge wins over a same-cycle clear and
    // brings its own polarity; an edge that lands on a still-pending event
    // keeps the original polarity and is dropped (or flagged as overrun).
    always_comb begin
        pend_d = pend_q;
        pol_d  = pol_q;
        if (edgeEnabled && (!pend_q || clr_i)) begin
            pend_d = 1'b1;
            pol_d  = in_i;
        end else if (clr_i) begin
            pend_d = 1'b0;
        end
    end

    // Level history and pending-event registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            prevLevel_q <= 1'b0;
            pend_q      <= 1'b0;
            pol_q       <= 1'b0;
        end else begin
            prevLevel_q <= in_i;
            pend_q      <= pend_d;
            pol_q       <= pol_d;
        end
    end

    assign pend_o = pend_q;
    assign pol_o  = pol_q;

`ifdef EDGE_ARB_OVERRUN_EN
    logic ovr_q;

    // Sticky overrun: an enabled edge arrived while an older event was still
    // waiting and was not being handed over in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_q <= 1'b0;
        end else if (edgeEnabled && pend_q && !clr_i) begin
            ovr_q <= 1'b1;
        end
    end

    assign ovr_o = ovr_q;
`endif

endmodule

// File: rtl/edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// edge_event_arbiter
//
// Multi-channel edge-event controller. Each of N_CH level inputs has its own
// dual-edge detector (edge_arb_chan); pending events are handed out one at a
// time over a valid/ready port using round-robin arbitration.
//
// Optional feature macro: EDGE_ARB_OVERRUN_EN adds the overrun_o port with
// sticky per-channel overrun flags.
//
// Parameters:
//   N_CH   number of input channels (2..16)
//   CH_W   channel-index width, derived from N_CH
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   in_i         in   level inputs, synchronous to clk
//   mode_i       in   per-channel mode, channel i at [2i+1:2i]
//   evt_valid_o  out  an event is being presented
//   evt_ready_i  in   consumer accepts the presented event
//   evt_ch_o     out  channel index of the presented event
//   evt_rise_o   out  1 = rising edge, 0 = falling edge
//   overrun_o    out  sticky overrun flags (only with EDGE_ARB_OVERRUN_EN)
// ---------------------------------------------------------------------------
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   in_i,
    input  logic [2*N_CH-1:0] mode_i,
    output logic              evt_valid_o,
    input  logic              evt_ready_i,
    output logic [CH_W-1:0]   evt_ch_o,
    output logic              evt_rise_o
`ifdef EDGE_ARB_OVERRUN_EN
    ,
    output logic [N_CH-1:0]   overrun_o
`endif
);

    arb_state_t      state_q;
    logic [CH_W-1:0] ptr_q;
    logic            evtValid_q;
    logic [CH_W-1:0] evtCh_q;
    logic            evtRise_q;

    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] pol;
    logic [N_CH-1:0] clr;
    logic            handshake;
    logic            anyPend;
    logic [CH_W-1:0] selCh;

    assign handshake = evtValid_q && evt_ready_i;
    assign anyPend   = |pend;

`ifdef EDGE_ARB_OVERRUN_EN
    logic [N_CH-1:0] ovr;
    assign overrun_o = ovr;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : gChan
        // Only the channel currently being presented is cleared on handshake.
        assign clr[i] = handshake && (evtCh_q == CH_W'(i));

        edge_arb_chan uChan (
            .clk    (clk),
            .reset  (reset),
            .in_i   (in_i[i]),
            .mode_i (mode_i[2*i+1:2*i]),
            .clr_i  (clr[i]),
            .pend_o (pend[i]),
            .pol_o  (pol[i])
`ifdef EDGE_ARB_OVERRUN_EN
            ,
            .ovr_o  (ovr[i])
`endif
        );
    end

    // Round-robin search: walk from the channel after the last one served,
    // wrapping past N_CH-1 to 0, and take the first pending channel found.
    always_comb begin
        logic            found;
        logic [CH_W-1:0] cand;
        selCh = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = CH_W'((int'(ptr_q) + k) % N_CH);
            if (!found && pend[cand]) begin
                selCh = cand;
                found = 1'b1;
            end
        end
    end

    // Arbiter FSM with registered outputs. IDLE picks the next winner and
    // captures its index and polarity; PRESENT holds them stable until the
    // consumer takes the event, then records the winner as the new pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= CH_W'(N_CH - 1);
            evtValid_q <= 1'b0;
            evtCh_q    <= '0;
            evtRise_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (anyPend) begin
                        evtCh_q    <= selCh;
                        evtRise_q  <= pol[selCh];
                        evtValid_q <= 1'b1;
                        state_q    <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (evt_ready_i) begin
                        evtValid_q <= 1'b0;
                        ptr_q      <= evtCh_q;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    evtValid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign evt_valid_o = evtValid_q;
    assign evt_ch_o    = evtCh_q;
    assign evt_rise_o  = evtRise_q;

endmodule
